instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, fixed at 2, meaning instruction buffer entries; other values are unsupported.
REQ-003 Port: clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Port: imem_req  out  1  fetch request, held high until accepted.
REQ-006 Port: imem_addr  out  32  fetch address, word aligned, stable while imem_req is high.
REQ-007 Port: imem_valid  in  1  response strobe; the transfer completes on an edge where imem_req and imem_valid are both high.
REQ-008 Port: imem_rdata  in  32  instruction word, valid with imem_valid.
REQ-009 Port: redirect  in  1  taken branch, JAL or JALR from decode; one-cycle pulse.
REQ-010 Port: redirect_pc  in  32  new fetch address, valid with redirect.
REQ-011 Port: dec_valid  out  1  buffer head holds an instruction.
REQ-012 Port: dec_ready  in  1  decode consumes the head on an edge where dec_valid and dec_ready are both high.
REQ-013 Port: instr  out  32  head instruction word.
REQ-014 Port: opcode  out  7  instr[6:0].
REQ-015 Port: funct3  out  3  instr[14:12].
REQ-016 Port: funct7  out  7  instr[31:25].
REQ-017 Port: pc_out  out  32  address of the head instruction.

Function
REQ-018 State machine: FETCH drives imem_req=1; WAIT_ROOM drives imem_req=0 because the buffer is full; DISCARD drives imem_req=1 and drops the returned data.
REQ-019 In FETCH and DISCARD, imem_addr SHALL equal fetch_pc.
REQ-020 On a completed transfer in FETCH: push {fetch_pc, imem_rdata}; fetch_pc += 4 (mod 2^32, wraps from 0xFFFF_FFFC to 0); go to WAIT_ROOM if resulting count==2, else stay in FETCH.
REQ-021 In WAIT_ROOM, return to FETCH in the cycle after count drops below 2.
REQ-022 The buffer SHALL be a 2-entry FIFO; a simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-023 dec_valid SHALL be (count != 0); instr, opcode, funct3, funct7 and pc_out SHALL come combinationally from the head entry.
REQ-024 Redirect has priority over push and pop: flush the buffer (count=0) at the next edge and set fetch_pc = {redirect_pc[31:2], 2'b00}.
REQ-025 If redirect occurs in FETCH while the request is not completing that edge, go to DISCARD. imem_addr SHALL hold the old address until imem_valid. Then drop the data, go to FETCH and issue the redirect address on the following cycle.
REQ-026 Redirect on the same edge a transfer completes SHALL drop that data; next state is FETCH with the redirect address.
REQ-027 Redirect in WAIT_ROOM or DISCARD SHALL update the target address; a second redirect during DISCARD replaces the first.
REQ-028 Fetch-to-decode latency SHALL be one cycle: data accepted at edge N appears at dec_valid after edge N when the buffer was empty.

Reset
REQ-029 While rst is high: imem_req=0, count=0, dec_valid=0, fetch_pc=RESET_PC, state FETCH, and any outstanding request is abandoned.
REQ-030 In the first cycle after rst falls, imem_req=1 and imem_addr=RESET_PC.
REQ-031 Reset asserted mid-operation SHALL override redirect, push and pop.

Verification
REQ-032 Reset release, memory valid every cycle, dec_ready=1 -> addresses 0,4,8,...; pc_out lags imem_addr by 1 cycle; opcode/funct3/funct7 match the slices of the word.
REQ-033 dec_ready=0, memory always valid -> exactly 2 pushes (pc 0, 4), then imem_req=0; after one pop, the next request is addr 8.
REQ-034 Redirect to 0x0000_0103 while a request to 0x10 waits 3 cycles -> addr stays 0x10 until valid, that data is dropped, the next request is 0x100 and dec_valid=0 throughout.
REQ-035 Redirect on the same edge as completion and pop with count=1 -> buffer empty, next addr=redirect target.
REQ-036 RESET_PC=0xFFFF_FFF8 -> fetches FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 rst pulsed while count=2 and in DISCARD -> dec_valid=0 next cycle, then fetch at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch front end. Issues word-aligned fetch requests to an
// instruction memory, captures returned words into a 2-entry instruction
// buffer, and presents the buffer head (word, PC and decoded fields) to the
// decode stage. Redirects from decode (taken branch, JAL, JALR) flush the
// buffer and retarget fetch; a request already on the bus when a redirect
// arrives is allowed to finish and its data is dropped.
//
// Parameters
//   RESET_PC    : first fetch address after reset
//   DEPTH       : instruction buffer entries (only 2 is supported)
//
// Ports
//   clk         : in  1   clock, all state updates on the rising edge
//   rst         : in  1   synchronous, active-high reset
//   imem_req    : out 1   fetch request, held until accepted
//   imem_addr   : out 32  fetch address, stable while imem_req is high
//   imem_valid  : in  1   response strobe; transfer = imem_req & imem_valid
//   imem_rdata  : in  32  instruction word, valid with imem_valid
//   redirect    : in  1   one-cycle pulse from decode: new fetch target
//   redirect_pc : in  32  new fetch address (low two bits ignored)
//   dec_valid   : out 1   buffer head holds an instruction
//   dec_ready   : in  1   decode consumes the head when dec_valid is high
//   instr       : out 32  head instruction word
//   opcode      : out 7   instr[6:0]
//   funct3      : out 3   instr[14:12]
//   funct7      : out 7   instr[31:25]
//   pc_out      : out 32  address of the head instruction
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [31:0] pc_out
);

    // Fetch state machine encoding.
    localparam logic [1:0] ST_FETCH     = 2'd0;  // request outstanding, data kept
    localparam logic [1:0] ST_WAIT_ROOM = 2'd1;  // buffer full, no request
    localparam logic [1:0] ST_DISCARD   = 2'd2;  // finish stale request, drop data

    localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]  state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;    // next address to fetch (or redirect target)
    logic [31:0] hold_addr_q, hold_addr_d;  // address of the stale request in DISCARD
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;

    // Buffer storage: PC and instruction word per entry.
    logic [31:0] buf_pc_q    [2];
    logic [31:0] buf_instr_q [2];

    logic transfer;
    logic push;
    logic pop;

    // Only the word-aligned part of the redirect target is used.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // Gated by rst so that nothing is requested or presented during reset,
    // including the very first reset cycle before the registers clear.
    assign imem_req  = !rst && ((state_q == ST_FETCH) || (state_q == ST_DISCARD));
    // In DISCARD the bus must keep showing the abandoned request's address
    // while fetch_pc_q already holds the redirect target.
    assign imem_addr = (state_q == ST_DISCARD) ? hold_addr_q : fetch_pc_q;

    assign dec_valid = !rst && (count_q != 2'd0);
    assign instr     = buf_instr_q[rd_ptr_q];
    assign pc_out    = buf_pc_q[rd_ptr_q];
    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];

    assign transfer = imem_req && imem_valid;
    // Data is only kept in FETCH, and a redirect on the same edge drops it.
    assign push     = (state_q == ST_FETCH) && transfer && !redirect;
    assign pop      = dec_valid && dec_ready;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default first so no latch is
    // inferred on paths that do not update it.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        hold_addr_d = hold_addr_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;

        if (redirect) begin
            // Redirect dominates push and pop: flush and retarget.
            count_d    = 2'd0;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            case (state_q)
                ST_FETCH: begin
                    if (transfer) begin
                        state_d = ST_FETCH;
                    end else begin
                        // Request is on the bus and cannot be withdrawn.
                        state_d     = ST_DISCARD;
                        hold_addr_d = fetch_pc_q;
                    end
                end
                ST_WAIT_ROOM: state_d = ST_FETCH;
                ST_DISCARD:   state_d = transfer ? ST_FETCH : ST_DISCARD;
                default:      state_d = ST_FETCH;
            endcase
        end else begin
            if (push) begin
                wr_ptr_d = !wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = !rd_ptr_q;
            end
            count_d = count_q + 2'(push) - 2'(pop);

            case (state_q)
                ST_FETCH: begin
                    if (push) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        if (count_d == FULL_COUNT) begin
                            state_d = ST_WAIT_ROOM;
                        end
                    end
                end
                ST_WAIT_ROOM: begin
                    // Leave as soon as the pop edge frees an entry.
                    if (count_d < FULL_COUNT) begin
                        state_d = ST_FETCH;
                    end
                end
                ST_DISCARD: begin
                    if (transfer) begin
                        state_d = ST_FETCH;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            fetch_pc_q  <= {RESET_PC[31:2], 2'b00};
            hold_addr_q <= {RESET_PC[31:2], 2'b00};
            count_q     <= 2'd0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            hold_addr_q <= hold_addr_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
        end
    end

    // -----------------------------------------------------------------------
    // Buffer storage
    // -----------------------------------------------------------------------
    // NOTE: the storage is deliberately not reset; entries are only ever
    // read when count_q marks them valid, so their power-up value is unseen.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            buf_pc_q[wr_ptr_q]    <= fetch_pc_q;
            buf_instr_q[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit. Inputs are driven on the falling edge
// and outputs are sampled 1 ns later, well away from the rising edge. The
// instruction memory is a fixed address hash so every fetched word is known.
// A second instance with RESET_PC = 0xFFFF_FFF8 shares the stimulus and is
// only observed right after the first reset release to see the wrap.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_valid;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        dec_ready;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        dec_valid;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] pc_out;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic        w_dec_valid;
    logic [31:0] w_instr;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_pc_out;

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0033;
    endfunction

    assign imem_rdata = mem_word(imem_addr);
    assign w_rdata    = mem_word(w_addr);

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .instr(instr), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .pc_out(pc_out)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_valid(imem_valid), .imem_rdata(w_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .dec_valid(w_dec_valid), .dec_ready(dec_ready),
        .instr(w_instr), .opcode(w_opcode), .funct3(w_funct3), .funct7(w_funct7),
        .pc_out(w_pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Two reset cycles with quiet inputs; returns in the second one.
    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; imem_valid = 1'b0; dec_ready = 1'b0; redirect = 1'b0;
        @(negedge clk); #1;
        check("rst_req", imem_req, 1'b0);
        check("rst_dvalid", dec_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w;
        rst = 1'b1; imem_valid = 1'b0; dec_ready = 1'b0;
        redirect = 1'b0; redirect_pc = 32'h0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        #1;
        check("por_req", imem_req, 1'b0);
        check("por_dvalid", dec_valid, 1'b0);
        check("por_wreq", w_req, 1'b0);

        // ---------------- streaming, wrap of second instance ----------------
        @(negedge clk); rst = 1'b0; imem_valid = 1'b1; dec_ready = 1'b1; #1;
        check("s_req0", imem_req, 1'b1);
        check("s_addr0", imem_addr, 32'h0);
        check("s_dv0", dec_valid, 1'b0);
        check("w_addr0", w_addr, 32'hFFFF_FFF8);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); #1;
            w = mem_word(32'(4 * (k - 1)));
            check("s_addr", imem_addr, 32'(4 * k));
            check("s_dv", dec_valid, 1'b1);
            check("s_pc", pc_out, 32'(4 * (k - 1)));
            check("s_instr", instr, w);
            check("s_opcode", opcode, w[6:0]);
            check("s_funct3", funct3, w[14:12]);
            check("s_funct7", funct7, w[31:25]);
            if (k == 1) check("w_addr1", w_addr, 32'hFFFF_FFFC);
            if (k == 2) check("w_addr2", w_addr, 32'h0000_0000);
        end

        // ---------------- back-pressure: buffer fills ----------------
        apply_reset();
        @(negedge clk); rst = 1'b0; imem_valid = 1'b1; dec_ready = 1'b0; #1;
        check("bp_addr0", imem_addr, 32'h0);
        @(negedge clk); #1;
        check("bp_req1", imem_req, 1'b1);
        check("bp_addr1", imem_addr, 32'h4);
        check("bp_pc1", pc_out, 32'h0);
        @(negedge clk); #1;
        check("bp_req2", imem_req, 1'b0);
        @(negedge clk); dec_ready = 1'b1; #1;
        check("bp_req3", imem_req, 1'b0);
        check("bp_pc3", pc_out, 32'h0);
        @(negedge clk); dec_ready = 1'b0; #1;
        check("bp_req4", imem_req, 1'b1);
        check("bp_addr4", imem_addr, 32'h8);
        check("bp_pc4", pc_out, 32'h4);
        @(negedge clk); #1;
        check("bp_req5", imem_req, 1'b0);
        check("bp_dv5", dec_valid, 1'b1);

        // ---------------- redirect during a stalled request ----------------
        apply_reset();
        @(negedge clk); rst = 1'b0; imem_valid = 1'b1; dec_ready = 1'b1;
        repeat (3) @(negedge clk);
        @(negedge clk); imem_valid = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0103; #1;
        check("rd_addr4", imem_addr, 32'h10);
        @(negedge clk); redirect = 1'b0; #1;
        check("rd_addr5", imem_addr, 32'h10);
        check("rd_req5", imem_req, 1'b1);
        check("rd_dv5", dec_valid, 1'b0);
        @(negedge clk); imem_valid = 1'b1; #1;
        check("rd_addr6", imem_addr, 32'h10);
        check("rd_dv6", dec_valid, 1'b0);
        @(negedge clk); imem_valid = 1'b0; #1;
        check("rd_addr7", imem_addr, 32'h100);
        check("rd_req7", imem_req, 1'b1);
        check("rd_dv7", dec_valid, 1'b0);
        @(negedge clk); imem_valid = 1'b1; #1;
        check("rd_dv8", dec_valid, 1'b0);
        check("rd_addr8", imem_addr, 32'h100);
        @(negedge clk); #1;
        check("rd_dv9", dec_valid, 1'b1);
        check("rd_pc9", pc_out, 32'h100);
        check("rd_instr9", instr, mem_word(32'h100));
        check("rd_addr9", imem_addr, 32'h104);

        // ---------------- redirect + completion + pop on one edge ----------------
        redirect = 1'b1; redirect_pc = 32'h2000_0046;
        @(negedge clk); redirect = 1'b0; #1;
        check("rc_dv", dec_valid, 1'b0);
        check("rc_req", imem_req, 1'b1);
        check("rc_addr", imem_addr, 32'h2000_0044);
        @(negedge clk); #1;
        check("rc_dv2", dec_valid, 1'b1);
        check("rc_pc2", pc_out, 32'h2000_0044);
        check("rc_addr2", imem_addr, 32'h2000_0048);

        // ---------------- double redirect in DISCARD, reset in DISCARD ----------------
        apply_reset();
        @(negedge clk); rst = 1'b0; redirect = 1'b1; redirect_pc = 32'h40; #1;
        check("dd_addr0", imem_addr, 32'h0);
        @(negedge clk); redirect_pc = 32'h80; #1;
        check("dd_addr1", imem_addr, 32'h0);
        @(negedge clk); redirect = 1'b0; imem_valid = 1'b1; #1;
        check("dd_addr2", imem_addr, 32'h0);
        @(negedge clk); imem_valid = 1'b0; redirect = 1'b1; redirect_pc = 32'h200; #1;
        check("dd_addr3", imem_addr, 32'h80);
        check("dd_dv3", dec_valid, 1'b0);
        @(negedge clk); redirect = 1'b0; #1;
        check("dd_addr4", imem_addr, 32'h80);
        @(negedge clk); rst = 1'b1; #1;
        check("dr_req", imem_req, 1'b0);
        check("dr_dv", dec_valid, 1'b0);
        @(negedge clk); rst = 1'b0; #1;
        check("dr_req1", imem_req, 1'b1);
        check("dr_addr1", imem_addr, 32'h0);
        check("dr_dv1", dec_valid, 1'b0);
        @(negedge clk); imem_valid = 1'b1; #1;
        check("dr_addr2", imem_addr, 32'h0);
        @(negedge clk); #1;
        check("dr_dv3", dec_valid, 1'b1);
        check("dr_pc3", pc_out, 32'h0);
        check("dr_addr3", imem_addr, 32'h4);

        // ---------------- reset with a full buffer ----------------
        @(negedge clk); #1;
        check("fr_req", imem_req, 1'b0);
        check("fr_dv", dec_valid, 1'b1);
        @(negedge clk); rst = 1'b1; #1;
        check("fr_dv_rst", dec_valid, 1'b0);
        check("fr_req_rst", imem_req, 1'b0);
        @(negedge clk); rst = 1'b0; imem_valid = 1'b0; #1;
        check("fr_dv1", dec_valid, 1'b0);
        check("fr_req1", imem_req, 1'b1);
        check("fr_addr1", imem_addr, 32'h0);

        // ---------------- redirect while waiting for room ----------------
        @(negedge clk); imem_valid = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        check("wr_req", imem_req, 1'b0);
        redirect = 1'b1; redirect_pc = 32'h300;
        @(negedge clk); redirect = 1'b0; #1;
        check("wr_req1", imem_req, 1'b1);
        check("wr_addr1", imem_addr, 32'h300);
        check("wr_dv1", dec_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
